// File: rtl/pipe_pkg.sv
// Shared encodings for the handshaked pipeline stage register.
// The state encoding doubles as the held-beat count.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    return OCC_W'(s);
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One {valid, ctrl, data} holding register; clear beats load, reset beats both.
// Clear always drops valid and ctrl; data is only zeroed when clear_data is also set.
module pipe_skid_slot #(
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_clear_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (i_clear_data) begin
        r_data <= '0;
      end
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a main slot driving the outputs and a skid slot behind it.
// One-cycle latency, full throughput; in_ready_o is registered so back-pressure never ripples combinationally.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned CTRL_W            = 6,
  parameter bit          FLUSH_CLEARS_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [OCC_W-1:0]  occupancy_o
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_vld;
  logic              w_skid_vld;
  logic              w_main_ld;
  logic              w_main_clr;
  logic              w_skid_ld;
  logic              w_skid_clr;
  logic              w_clr_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_main_src_ctrl;
  logic [DATA_W-1:0] w_main_src_data;

  assign w_in_fire  = in_valid_i & r_in_ready;
  assign w_out_fire = w_main_vld & out_ready_i;
  assign w_clr_data = flush_i & FLUSH_CLEARS_DATA;

  always_comb begin
    w_state_nxt = r_state;
    w_main_ld   = 1'b0;
    w_main_clr  = 1'b0;
    w_skid_ld   = 1'b0;
    w_skid_clr  = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_ld   = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_ld = 1'b1;
        end else if (w_in_fire) begin
          w_skid_ld   = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (w_out_fire) begin
          w_main_clr  = 1'b1;
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_main_ld   = 1'b1;
          w_skid_clr  = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush overrides every handshake, including an accepted input beat.
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
      w_main_ld   = 1'b0;
      w_skid_ld   = 1'b0;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end
  end

  // Main refills from the skid slot whenever one is parked there, otherwise from the input.
  assign w_main_src_ctrl = w_skid_vld ? w_skid_ctrl : in_ctrl_i;
  assign w_main_src_data = w_skid_vld ? w_skid_data : in_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  pipe_skid_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_load      (w_main_ld),
    .i_clear     (w_main_clr),
    .i_clear_data(w_clr_data),
    .i_ctrl      (w_main_src_ctrl),
    .i_data      (w_main_src_data),
    .o_valid     (w_main_vld),
    .o_ctrl      (w_main_ctrl),
    .o_data      (w_main_data)
  );

  pipe_skid_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_load      (w_skid_ld),
    .i_clear     (w_skid_clr),
    .i_clear_data(w_clr_data),
    .i_ctrl      (in_ctrl_i),
    .i_data      (in_data_i),
    .o_valid     (w_skid_vld),
    .o_ctrl      (w_skid_ctrl),
    .o_data      (w_skid_data)
  );

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = w_main_vld;
  assign out_ctrl_o  = w_main_ctrl;
  assign out_data_o  = w_main_data;
  assign occupancy_o = occ_of(r_state);

endmodule
